// File: rtl/avg_share_scheduler.sv
`timescale 1ns / 1ps
// Round-robin owner of the shared averager: grants one enabled source a full burst,
// then stores the averaged result in that source's holding register.
module avg_share_scheduler #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned RES_W    = 12,
    parameter int unsigned LOG2_AVG = 4,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic [NUM_CH-1:0]        src_valid,
    input  logic [NUM_CH*DATA_W-1:0] src_data,
    output logic [NUM_CH-1:0]        src_ready,
    output logic                     avg_clear,
    output logic                     avg_in_valid,
    output logic [DATA_W-1:0]        avg_in_data,
    input  logic                     avg_in_ready,
    input  logic                     avg_out_valid,
    input  logic [RES_W-1:0]         avg_out_data,
    output logic [NUM_CH*RES_W-1:0]  ch_result,
    output logic [NUM_CH-1:0]        ch_result_valid,
    output logic [NUM_CH-1:0]        ch_update,
    output logic [1:0]               active_ch,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int unsigned CNT_W = LOG2_AVG + 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] BurstLen  = CNT_W'(1 << LOG2_AVG);
    localparam logic [CNT_W-1:0] BurstLast = CNT_W'((1 << LOG2_AVG) - 1);
    localparam logic [WD_W-1:0]  WdLast    = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StFlush, StStream, StWaitRes} state_e;

    state_e                    state_q, state_d;
    logic [1:0]                owner_q, owner_d;
    logic [1:0]                last_grant_q, last_grant_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [WD_W-1:0]           wdog_q, wdog_d;
    logic [NUM_CH*RES_W-1:0]   ch_result_q, ch_result_d;
    logic [NUM_CH-1:0]         ch_result_valid_q, ch_result_valid_d;
    logic [NUM_CH-1:0]         ch_update_q, ch_update_d;
    logic                      timeout_err_q, timeout_err_d;

    logic                      found;
    logic [1:0]                cand;
    int unsigned               idx;
    logic                      xfer;

    always_comb begin
        state_d           = state_q;
        owner_d           = owner_q;
        last_grant_d      = last_grant_q;
        cnt_d             = cnt_q;
        wdog_d            = wdog_q;
        ch_result_d       = ch_result_q;
        ch_result_valid_d = ch_result_valid_q;
        ch_update_d       = '0;
        timeout_err_d     = 1'b0;
        src_ready         = '0;
        avg_clear         = 1'b0;
        avg_in_valid      = 1'b0;
        avg_in_data       = '0;
        found             = 1'b0;
        cand              = '0;
        idx               = 0;
        xfer              = 1'b0;

        case (state_q)
            StIdle: begin
                // Search starts just past the last owner so every source gets a turn.
                for (int unsigned i = 1; i <= NUM_CH; i++) begin
                    idx = (int'(last_grant_q) + i) % NUM_CH;
                    if (!found && ch_enable[idx]) begin
                        found = 1'b1;
                        cand  = idx[1:0];
                    end
                end
                if (found) begin
                    owner_d = cand;
                    state_d = StFlush;
                end
            end
            StFlush: begin
                avg_clear = 1'b1;
                cnt_d     = '0;
                wdog_d    = '0;
                if (!ch_enable[owner_q]) begin
                    last_grant_d = owner_q;
                    state_d      = StIdle;
                end else begin
                    state_d = StStream;
                end
            end
            StStream: begin
                avg_in_valid       = src_valid[owner_q];
                avg_in_data        = src_data[owner_q*DATA_W +: DATA_W];
                src_ready[owner_q] = avg_in_ready;
                xfer               = src_valid[owner_q] & avg_in_ready;
                if (!ch_enable[owner_q]) begin
                    last_grant_d = owner_q;
                    state_d      = StIdle;
                end else if (xfer) begin
                    cnt_d  = (cnt_q == BurstLen) ? cnt_q : cnt_q + 1'b1;
                    wdog_d = '0;
                    if (cnt_q == BurstLast) state_d = StWaitRes;
                end else if (wdog_q == WdLast) begin
                    timeout_err_d = 1'b1;
                    last_grant_d  = owner_q;
                    state_d       = StIdle;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            StWaitRes: begin
                // Abort beats a result strobe; a result strobe beats the watchdog.
                if (!ch_enable[owner_q]) begin
                    last_grant_d = owner_q;
                    state_d      = StIdle;
                end else if (avg_out_valid) begin
                    ch_result_d[owner_q*RES_W +: RES_W] = avg_out_data;
                    ch_result_valid_d[owner_q]          = 1'b1;
                    ch_update_d[owner_q]                = 1'b1;
                    last_grant_d                        = owner_q;
                    state_d                             = StIdle;
                end else if (wdog_q == WdLast) begin
                    timeout_err_d = 1'b1;
                    last_grant_d  = owner_q;
                    state_d       = StIdle;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= StIdle;
            owner_q           <= '0;
            last_grant_q      <= 2'(NUM_CH - 1);
            cnt_q             <= '0;
            wdog_q            <= '0;
            ch_result_q       <= '0;
            ch_result_valid_q <= '0;
            ch_update_q       <= '0;
            timeout_err_q     <= 1'b0;
        end else begin
            state_q           <= state_d;
            owner_q           <= owner_d;
            last_grant_q      <= last_grant_d;
            cnt_q             <= cnt_d;
            wdog_q            <= wdog_d;
            ch_result_q       <= ch_result_d;
            ch_result_valid_q <= ch_result_valid_d;
            ch_update_q       <= ch_update_d;
            timeout_err_q     <= timeout_err_d;
        end
    end

    assign ch_result       = ch_result_q;
    assign ch_result_valid = ch_result_valid_q;
    assign ch_update       = ch_update_q;
    assign timeout_err     = timeout_err_q;
    assign active_ch       = owner_q;
    assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_avg_share_scheduler.sv
`timescale 1ns / 1ps
// Bench for avg_share_scheduler: averager model plus a scoreboard of expected grants and
// stored results, popped by an independent monitor.
module tb_avg_share_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  ch_enable = '0;
    logic [3:0]  src_valid = '0;
    // src3 = 0x44, src2 = 0x33, src1 = 0x80, src0 = 0x11
    logic [31:0] src_data = 32'h4433_8011;
    logic [3:0]  src_ready;
    logic        avg_clear, avg_in_valid, avg_in_ready;
    logic [7:0]  avg_in_data;
    logic        avg_out_valid;
    logic [11:0] avg_out_data;
    logic [47:0] ch_result;
    logic [3:0]  ch_result_valid, ch_update;
    logic [1:0]  active_ch;
    logic        busy, timeout_err;

    logic bp_en = 1'b0, bp_rand = 1'b1, mute = 1'b0;
    assign avg_in_ready = bp_en ? bp_rand : 1'b1;

    int total = 0;
    int bad   = 0;
    int grant_q[$];
    int res_ch_q[$];
    int res_val_q[$];

    avg_share_scheduler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ch_enable      (ch_enable),
        .src_valid      (src_valid),
        .src_data       (src_data),
        .src_ready      (src_ready),
        .avg_clear      (avg_clear),
        .avg_in_valid   (avg_in_valid),
        .avg_in_data    (avg_in_data),
        .avg_in_ready   (avg_in_ready),
        .avg_out_valid  (avg_out_valid),
        .avg_out_data   (avg_out_data),
        .ch_result      (ch_result),
        .ch_result_valid(ch_result_valid),
        .ch_update      (ch_update),
        .active_ch      (active_ch),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bp_en) bp_rand = 1'($urandom_range(0, 1));

    // Averager model: sums 16 samples, presents the sum two cycles after the last one.
    logic [4:0]  m_cnt;
    logic [11:0] m_sum;
    logic [1:0]  m_dly;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_sum <= 0; m_dly <= 0;
            avg_out_valid <= 1'b0; avg_out_data <= '0;
        end else begin
            avg_out_valid <= 1'b0;
            if (avg_clear) begin
                m_cnt <= 0; m_sum <= 0; m_dly <= 0;
            end else begin
                if (avg_in_valid && avg_in_ready && m_cnt < 16) begin
                    m_sum <= m_sum + 12'(avg_in_data);
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == 15) m_dly <= 2;
                end
                if (m_dly != 0) begin
                    m_dly <= m_dly - 1;
                    if (m_dly == 1 && !mute) begin
                        avg_out_valid <= 1'b1;
                        avg_out_data  <= m_sum;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT grants or stores.
    int xfers = 0;
    int m_ch, m_val;
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (avg_clear) begin
                xfers = 0;
                if (grant_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL grant: unexpected grant to %0d", active_ch);
                end else begin
                    chk("grant", 64'(active_ch), 64'(grant_q.pop_front()));
                end
            end
            if (busy) chk("nonowner_ready", 64'(src_ready & ~(4'b1 << active_ch)), 64'd0);
            if (avg_in_valid && avg_in_ready) xfers++;
            if (ch_update != 0) begin
                if (res_ch_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL update: unexpected ch_update 0x%0h", ch_update);
                end else begin
                    m_ch  = res_ch_q.pop_front();
                    m_val = res_val_q.pop_front();
                    chk("update_ch", 64'(ch_update), 64'(4'b1 << m_ch));
                    chk("result", 64'(ch_result[m_ch*12 +: 12]), 64'(m_val));
                    chk("result_valid", 64'(ch_result_valid[m_ch]), 64'd1);
                    chk("burst_xfers", 64'(xfers), 64'd16);
                end
            end
        end
    end

    task automatic expect_res(input int ch, input int val);
        res_ch_q.push_back(ch);
        res_val_q.push_back(val);
    endtask

    task automatic wait_upd(input int n);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (ch_update != 0) seen++;
        end
        chk("wait_updates", 64'(seen), 64'(n));
    endtask

    task automatic wait_xfers(input int n);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (avg_in_valid && avg_in_ready) seen++;
        end
        chk("wait_xfers", 64'(seen), 64'(n));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_src_ready", 64'(src_ready), 64'd0);
        chk("rst_avg_clear", 64'(avg_clear), 64'd0);
        chk("rst_avg_in_valid", 64'(avg_in_valid), 64'd0);
        chk("rst_avg_in_data", 64'(avg_in_data), 64'd0);
        chk("rst_ch_result", 64'(ch_result), 64'd0);
        chk("rst_result_valid", 64'(ch_result_valid), 64'd0);
        chk("rst_ch_update", 64'(ch_update), 64'd0);
        chk("rst_active_ch", 64'(active_ch), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    endtask

    initial begin
        int d;
        // Reset state
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;

        // Single source 1, re-granted twice in a row
        grant_q.push_back(1); grant_q.push_back(1);
        expect_res(1, 'h800); expect_res(1, 'h800);
        ch_enable = 4'b0010; src_valid = 4'b1111;
        wait_upd(2);
        ch_enable = 4'b0000;

        // Rotation from a fresh reset: 0,1,2,3,0
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        foreach (grant_q[i]) ; // nothing pending here
        grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(2);
        grant_q.push_back(3); grant_q.push_back(0);
        expect_res(0, 'h110); expect_res(1, 'h800); expect_res(2, 'h330);
        expect_res(3, 'h440); expect_res(0, 'h110);
        ch_enable = 4'b1111;
        wait_upd(5);
        ch_enable = 4'b0000;
        repeat (2) @(negedge clk);
        chk("valid_all", 64'(ch_result_valid), 64'hF);

        // Random backpressure
        bp_en = 1'b1;
        grant_q.push_back(1); grant_q.push_back(2);
        expect_res(1, 'h800); expect_res(2, 'h330);
        ch_enable = 4'b1111;
        wait_upd(2);
        ch_enable = 4'b0000;
        bp_en = 1'b0;

        // Abort source 2 after 7 transfers; source 3 follows
        repeat (2) @(negedge clk);
        grant_q.push_back(2);
        ch_enable = 4'b0100;
        wait_xfers(7);
        @(negedge clk);
        ch_enable = 4'b1000;
        grant_q.push_back(3);
        expect_res(3, 'h440);
        @(negedge clk);
        chk("abort_idle", 64'(busy), 64'd0);
        chk("abort_no_update", 64'(ch_update), 64'd0);
        chk("abort_keep_result", 64'(ch_result[2*12 +: 12]), 64'h330);
        wait_upd(1);
        ch_enable = 4'b0000;

        // Watchdog: averager stays silent
        repeat (2) @(negedge clk);
        mute = 1'b1;
        grant_q.push_back(0);
        ch_enable = 4'b0001;
        wait_xfers(16);
        d = 0;
        while (!timeout_err && d < 400) begin
            @(negedge clk);
            d++;
        end
        chk("timeout_latency", 64'(d), 64'd256);
        chk("timeout_no_update", 64'(ch_update), 64'd0);
        chk("timeout_idle", 64'(busy), 64'd0);
        chk("timeout_keep_result", 64'(ch_result[0 +: 12]), 64'h110);
        mute = 1'b0;
        grant_q.push_back(1);
        expect_res(1, 'h800);
        ch_enable = 4'b0011;
        @(negedge clk);
        chk("timeout_one_cycle", 64'(timeout_err), 64'd0);
        wait_upd(1);
        ch_enable = 4'b0000;

        // Reset mid-STREAM discards the burst; source 0 first afterwards
        repeat (2) @(negedge clk);
        grant_q.push_back(2);
        ch_enable = 4'b1111;
        wait_xfers(5);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        grant_q.push_back(0);
        expect_res(0, 'h110);
        wait_upd(1);
        ch_enable = 4'b0000;

        repeat (3) @(negedge clk);
        chk("queues_drained", 64'(grant_q.size() + res_ch_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/avg_share_scheduler.md
# avg_share_scheduler

Time-multiplexes the single shared averager between the four sample sources: PWM ramp, R2R ramp, PWM successive-approximation and R2R successive-approximation. The scheduler grants the averager to one enabled source at a time for a full burst of 2^LOG2_AVG samples, then captures the result into a per-source holding register and rotates round-robin. It sits between the ADC source blocks and the display menu mux, so every averaged reading the menu shows comes from this block's holding registers.

## Interface

Parameters:
- NUM_CH, 4: number of sources. Index 0 = PWM ramp, 1 = R2R ramp, 2 = PWM SAR, 3 = R2R SAR.
- DATA_W, 8: raw sample width.
- RES_W, 12: averager result width.
- LOG2_AVG, 4: log2 of samples per burst (16).
- TIMEOUT, 255: watchdog limit in cycles.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- ch_enable  in  NUM_CH  per-source enable, decoded from the menu selects.
- src_valid  in  NUM_CH  sample valid, per source.
- src_data  in  NUM_CH*DATA_W  samples; source i occupies bits [i*DATA_W +: DATA_W].
- src_ready  out  NUM_CH  sample accepted, per source.
- avg_clear  out  1  one-cycle flush pulse to the averager.
- avg_in_valid  out  1  sample valid to the averager.
- avg_in_data  out  DATA_W  sample to the averager.
- avg_in_ready  in  1  averager accepts a sample.
- avg_out_valid  in  1  averager result strobe.
- avg_out_data  in  RES_W  averager result.
- ch_result  out  NUM_CH*RES_W  per-source held result.
- ch_result_valid  out  NUM_CH  sticky: source has at least one stored result.
- ch_update  out  NUM_CH  one-cycle pulse when a source's result is written.
- active_ch  out  2  current owner index.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  one-cycle pulse when the watchdog fires.

## Operation

States: IDLE, FLUSH, STREAM, WAIT_RES.

- **IDLE**
  - Search ch_enable starting at last_grant+1 (mod NUM_CH) and take the first enabled source.
  - On a hit: owner = that index, go to FLUSH.
  - If no source is enabled, stay in IDLE.
- **FLUSH**
  - avg_clear = 1 for exactly one cycle.
  - Sample counter = 0, watchdog = 0.
  - Go to STREAM.
- **STREAM**
  - avg_in_valid = src_valid[owner]; avg_in_data = src_data of owner.
  - src_ready[owner] = avg_in_ready; every other bit of src_ready = 0.
  - These are combinational passthroughs.
  - A transfer is valid & ready in the same cycle; each transfer increments the counter and clears the watchdog.
  - When the 2^LOG2_AVG-th transfer occurs, go to WAIT_RES.
- **WAIT_RES**
  - avg_in_valid = 0.
  - On avg_out_valid: register avg_out_data into ch_result[owner], set ch_result_valid[owner], pulse ch_update[owner], set last_grant = owner, go to IDLE.
- **Abort**
  - If ch_enable[owner] drops in FLUSH, STREAM or WAIT_RES, go to IDLE next cycle.
  - No store and no ch_update.
  - last_grant = owner, so rotation advances past the aborted source.
- **Watchdog**
  - Counts cycles in STREAM without a transfer, and all cycles in WAIT_RES.
  - At TIMEOUT: pulse timeout_err, go to IDLE, last_grant = owner.
  - Held results are unchanged.
- **Stray strobes**
  - avg_out_valid outside WAIT_RES is ignored.
- **Simultaneous events**
  - If abort and avg_out_valid occur in the same cycle, abort wins (no store).
  - If the watchdog fires and avg_out_valid arrives in the same cycle, the store wins (no timeout_err).
- **Width**
  - The counter is LOG2_AVG+1 bits wide and saturates at the burst length; it never wraps.
- **Reset** (asynchronous, active-low)
  - State = IDLE, last_grant = NUM_CH-1 (so source 0 is granted first), active_ch = 0.
  - ch_result = 0, ch_result_valid = 0.
  - All pulse outputs = 0; busy = 0; src_ready = 0.
  - Reset asserted mid-burst discards the burst. The next grant after release is source 0.

## Timing

- Grant latency: the IDLE→FLUSH decision takes 1 cycle; FLUSH lasts 1 cycle; the first transfer can occur on the 3rd cycle after IDLE sees an enable.
- With continuous valid/ready, STREAM lasts exactly 2^LOG2_AVG cycles.
- ch_result and ch_update update on the cycle after avg_out_valid is sampled. The ch_update pulse and the new ch_result are visible in the same cycle.
- Back-to-back bursts: 1 IDLE cycle between a store and the next FLUSH.
- active_ch is registered and valid from FLUSH through the end of the burst.

## Test plan

- **Reset:** assert rst_n = 0 mid-STREAM.
  - Required: all outputs zero immediately, without waiting for a clock edge.
  - After release, with all sources enabled, source 0 is granted first.
- **Single source:** ch_enable = 4'b0010, source 1 data constant 0x80, averager model returns 0x800 two cycles after the 16th sample.
  - Required: avg_clear pulse, then exactly 16 transfers.
  - ch_result[1] = 0x800, ch_update[1] pulses once.
  - Then source 1 is re-granted.
- **Rotation:** all four sources enabled and always valid.
  - Required: grant order 0,1,2,3,0.
  - 16 transfers per burst, 4 distinct ch_update pulses.
- **Backpressure:** avg_in_ready toggles randomly.
  - Required: exactly 16 transfers per burst.
  - Non-owner src_ready stays 0 throughout.
- **Abort:** clear ch_enable[2] after 7 transfers of source 2's burst.
  - Required: IDLE next cycle, no ch_update[2], ch_result[2] unchanged.
  - Source 3 is granted next.
- **Timeout:** averager never asserts avg_out_valid.
  - Required: timeout_err pulses 255 cycles after WAIT_RES entry.
  - No store; rotation continues with the next enabled source.
